// File: rtl/spart_driver.sv
// Echo initiator for the SPART: programs the divisor, then reads each byte and writes it back.
// Accesses are 1-cycle registered strobes; an echo waits indefinitely for tbr.
module spart_driver #(
  parameter logic [15:0] DIV_4800  = 16'd650,
  parameter logic [15:0] DIV_9600  = 16'd325,
  parameter logic [15:0] DIV_19200 = 16'd162,
  parameter logic [15:0] DIV_38400 = 16'd80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  input  logic [7:0] databus_in,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  output logic [7:0] databus_out,
  output logic [7:0] echo_count
);

  // Each state names the access visible on the bus during that cycle;
  // START is the single quiet cycle after reset that precedes CFG_LO.
  typedef enum logic [2:0] {
    START,
    CFG_LO,
    CFG_HI,
    IDLE,
    READ_RX,
    WAIT_TBR,
    WRITE_TX
  } state_t;

  state_t     state;
  logic [1:0] cfg_shadow;
  logic [7:0] held;

  function automatic logic [15:0] div_of(input logic [1:0] sel);
    case (sel)
      2'b00:   div_of = DIV_4800;
      2'b01:   div_of = DIV_9600;
      2'b10:   div_of = DIV_19200;
      default: div_of = DIV_38400;
    endcase
  endfunction

  logic [15:0] div_shadow;
  logic [15:0] div_new;
  assign div_shadow = div_of(cfg_shadow);
  assign div_new    = div_of(br_cfg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= START;
      iocs        <= 1'b0;
      iorw        <= 1'b1;
      ioaddr      <= 2'b00;
      databus_out <= 8'h00;
      echo_count  <= 8'h00;
      held        <= 8'h00;
      cfg_shadow  <= br_cfg;
    end else begin
      iocs        <= 1'b0;
      iorw        <= 1'b1;
      ioaddr      <= 2'b00;
      databus_out <= 8'h00;
      case (state)
        START: begin
          state       <= CFG_LO;
          iocs        <= 1'b1;
          iorw        <= 1'b0;
          ioaddr      <= 2'b10;
          databus_out <= div_shadow[7:0];
        end
        CFG_LO: begin
          state       <= CFG_HI;
          iocs        <= 1'b1;
          iorw        <= 1'b0;
          ioaddr      <= 2'b11;
          databus_out <= div_shadow[15:8];
        end
        CFG_HI: state <= IDLE;
        IDLE: begin
          if (rda) begin
            state <= READ_RX;
            iocs  <= 1'b1;
          end else if (br_cfg != cfg_shadow) begin
            // Shadow is not yet updated here, so the low byte uses the live select.
            cfg_shadow  <= br_cfg;
            state       <= CFG_LO;
            iocs        <= 1'b1;
            iorw        <= 1'b0;
            ioaddr      <= 2'b10;
            databus_out <= div_new[7:0];
          end
        end
        READ_RX: begin
          held  <= databus_in;
          state <= WAIT_TBR;
        end
        WAIT_TBR: begin
          if (tbr) begin
            state       <= WRITE_TX;
            iocs        <= 1'b1;
            iorw        <= 1'b0;
            databus_out <= held;
          end
        end
        WRITE_TX: begin
          echo_count <= echo_count + 8'd1;
          state      <= IDLE;
        end
        default: state <= START;
      endcase
    end
  end

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver: divisor programming, echo timing, reprogram ordering, reset, wrap.
module tb_spart_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  logic       rda;
  logic       tbr;
  logic [7:0] databus_in;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] databus_out;
  logic [7:0] echo_count;

  int n_checks = 0;
  int n_fail   = 0;

  spart_driver dut (
    .clk         (clk),
    .rst         (rst),
    .br_cfg      (br_cfg),
    .rda         (rda),
    .tbr         (tbr),
    .databus_in  (databus_in),
    .iocs        (iocs),
    .iorw        (iorw),
    .ioaddr      (ioaddr),
    .databus_out (databus_out),
    .echo_count  (echo_count)
  );

  always #5 clk = ~clk;

  // Advance to the next cycle; outputs are then stable and inputs may be set for this cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; br_cfg = 2'b01; rda = 1'b0; tbr = 1'b0; databus_in = 8'h00;
    step();
    step();
    n_checks++;
    if ({iocs, iorw, ioaddr, databus_out, echo_count} !== {1'b0, 1'b1, 2'b00, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_outputs: got cs=%b rw=%b addr=%b dout=%h cnt=%h, want 0 1 00 00 00",
               iocs, iorw, ioaddr, databus_out, echo_count);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if ({iocs, iorw, ioaddr, databus_out} !== {1'b1, 1'b0, 2'b10, 8'h45}) begin
      n_fail++;
      $display("FAIL cfg_lo_9600: got cs=%b rw=%b addr=%b dout=%h, want 1 0 10 45",
               iocs, iorw, ioaddr, databus_out);
    end
    step();
    n_checks++;
    if ({iocs, iorw, ioaddr, databus_out} !== {1'b1, 1'b0, 2'b11, 8'h01}) begin
      n_fail++;
      $display("FAIL cfg_hi_9600: got cs=%b rw=%b addr=%b dout=%h, want 1 0 11 01",
               iocs, iorw, ioaddr, databus_out);
    end
    step();
    n_checks++;
    if ({iocs, iorw, ioaddr, databus_out} !== {1'b0, 1'b1, 2'b00, 8'h00}) begin
      n_fail++;
      $display("FAIL cfg_done_idle: got cs=%b rw=%b addr=%b dout=%h, want 0 1 00 00",
               iocs, iorw, ioaddr, databus_out);
    end
  endtask

  task automatic test_echo();
    rda = 1'b1; databus_in = 8'hAA; tbr = 1'b1;
    step();
    n_checks++;
    if ({iocs, iorw, ioaddr} !== {1'b1, 1'b1, 2'b00}) begin
      n_fail++;
      $display("FAIL echo_read: got cs=%b rw=%b addr=%b, want 1 1 00", iocs, iorw, ioaddr);
    end
    rda = 1'b0;
    step();
    step();
    n_checks++;
    if ({iocs, iorw, ioaddr, databus_out, echo_count} !== {1'b1, 1'b0, 2'b00, 8'hAA, 8'h00}) begin
      n_fail++;
      $display("FAIL echo_write: got cs=%b rw=%b addr=%b dout=%h cnt=%h, want 1 0 00 aa 00",
               iocs, iorw, ioaddr, databus_out, echo_count);
    end
    tbr = 1'b0;
    step();
    n_checks++;
    if ({iocs, echo_count} !== {1'b0, 8'h01}) begin
      n_fail++;
      $display("FAIL echo_count_1: got cs=%b cnt=%h, want 0 01", iocs, echo_count);
    end
  endtask

  task automatic test_tbr_wait();
    int bad = 0;
    rda = 1'b1; databus_in = 8'h39; tbr = 1'b0;
    step();
    rda = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (iocs !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL tbr_wait_quiet: got %0d strobe cycles during wait, want 0", bad);
    end
    tbr = 1'b1;
    databus_in = 8'h00;
    step();
    n_checks++;
    if ({iocs, iorw, ioaddr, databus_out} !== {1'b1, 1'b0, 2'b00, 8'h39}) begin
      n_fail++;
      $display("FAIL tbr_wait_write: got cs=%b rw=%b addr=%b dout=%h, want 1 0 00 39",
               iocs, iorw, ioaddr, databus_out);
    end
    tbr = 1'b0;
    step();
    n_checks++;
    if (echo_count !== 8'h02) begin
      n_fail++;
      $display("FAIL echo_count_2: got %h, want 02", echo_count);
    end
  endtask

  task automatic test_cfg_race();
    br_cfg = 2'b11; rda = 1'b1; databus_in = 8'h5C; tbr = 1'b1;
    step();
    n_checks++;
    if ({iocs, iorw, ioaddr} !== {1'b1, 1'b1, 2'b00}) begin
      n_fail++;
      $display("FAIL race_read_first: got cs=%b rw=%b addr=%b, want 1 1 00", iocs, iorw, ioaddr);
    end
    rda = 1'b0;
    step();
    step();
    n_checks++;
    if ({iocs, iorw, ioaddr, databus_out} !== {1'b1, 1'b0, 2'b00, 8'h5C}) begin
      n_fail++;
      $display("FAIL race_write: got cs=%b rw=%b addr=%b dout=%h, want 1 0 00 5c",
               iocs, iorw, ioaddr, databus_out);
    end
    tbr = 1'b0;
    step();
    step();
    n_checks++;
    if ({iocs, iorw, ioaddr, databus_out} !== {1'b1, 1'b0, 2'b10, 8'h50}) begin
      n_fail++;
      $display("FAIL race_cfg_lo: got cs=%b rw=%b addr=%b dout=%h, want 1 0 10 50",
               iocs, iorw, ioaddr, databus_out);
    end
    step();
    n_checks++;
    if ({iocs, iorw, ioaddr, databus_out} !== {1'b1, 1'b0, 2'b11, 8'h00}) begin
      n_fail++;
      $display("FAIL race_cfg_hi: got cs=%b rw=%b addr=%b dout=%h, want 1 0 11 00",
               iocs, iorw, ioaddr, databus_out);
    end
    step();
    n_checks++;
    if ({iocs, echo_count} !== {1'b0, 8'h03}) begin
      n_fail++;
      $display("FAIL race_idle: got cs=%b cnt=%h, want 0 03", iocs, echo_count);
    end
  endtask

  task automatic test_reset_mid();
    int tx_writes = 0;
    rda = 1'b1; databus_in = 8'h77; tbr = 1'b0;
    step();
    rda = 1'b0;
    step();
    rst = 1'b1;
    step();
    n_checks++;
    if ({iocs, echo_count} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL midreset_state: got cs=%b cnt=%h, want 0 00", iocs, echo_count);
    end
    rst = 1'b0;
    tbr = 1'b1;
    step();
    if (iocs && !iorw && ioaddr == 2'b00) tx_writes++;
    n_checks++;
    if ({iocs, iorw, ioaddr, databus_out} !== {1'b1, 1'b0, 2'b10, 8'h50}) begin
      n_fail++;
      $display("FAIL midreset_cfg_lo: got cs=%b rw=%b addr=%b dout=%h, want 1 0 10 50",
               iocs, iorw, ioaddr, databus_out);
    end
    step();
    if (iocs && !iorw && ioaddr == 2'b00) tx_writes++;
    n_checks++;
    if ({iocs, iorw, ioaddr, databus_out} !== {1'b1, 1'b0, 2'b11, 8'h00}) begin
      n_fail++;
      $display("FAIL midreset_cfg_hi: got cs=%b rw=%b addr=%b dout=%h, want 1 0 11 00",
               iocs, iorw, ioaddr, databus_out);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (iocs && !iorw && ioaddr == 2'b00) tx_writes++;
    end
    n_checks++;
    if (tx_writes != 0 || echo_count !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_no_tx: got %0d tx writes cnt=%h, want 0 writes cnt 00",
               tx_writes, echo_count);
    end
    tbr = 1'b0;
  endtask

  // rda stays high throughout, so each read follows the post-write IDLE cycle directly.
  task automatic test_back_to_back();
    int bad_rd = 0;
    int bad_wr = 0;
    int bad_idle = 0;
    logic [7:0] d;
    rda = 1'b1; tbr = 1'b1;
    for (int i = 0; i < 256; i++) begin
      d = 8'(i) ^ 8'hA5;
      databus_in = d;
      step();
      if ({iocs, iorw, ioaddr} !== {1'b1, 1'b1, 2'b00}) bad_rd++;
      step();
      databus_in = 8'h00;
      step();
      if ({iocs, iorw, ioaddr, databus_out} !== {1'b1, 1'b0, 2'b00, d}) bad_wr++;
      step();
      if (iocs !== 1'b0) bad_idle++;
      if (i == 254) begin
        n_checks++;
        if (echo_count !== 8'hFF) begin
          n_fail++;
          $display("FAIL count_255: got %h, want ff", echo_count);
        end
      end
      if (i == 255) rda = 1'b0;
    end
    n_checks++;
    if (bad_rd != 0 || bad_idle != 0) begin
      n_fail++;
      $display("FAIL b2b_reads: got %0d bad reads %0d bad idles, want 0 0", bad_rd, bad_idle);
    end
    n_checks++;
    if (bad_wr != 0) begin
      n_fail++;
      $display("FAIL b2b_echo_data: got %0d wrong writes, want 0", bad_wr);
    end
    step();
    n_checks++;
    if ({iocs, echo_count} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL count_wrap: got cs=%b cnt=%h, want 0 00", iocs, echo_count);
    end
  endtask

  initial begin
    test_reset();
    test_echo();
    test_tbr_wait();
    test_cfg_race();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spart_driver.md
Name: spart_driver

Overview:
Bus-side initiator for the SPART, and the counterpart of the SPART bus interface: it drives iocs/iorw/ioaddr and the data bus that the transmitter and receiver respond to. After reset it programs the baud divisor selected by br_cfg. It then runs an echo loop: poll rda, read the received byte, wait for tbr, and write the byte back to the transmit buffer. It sits beside the SPART in the lab top level, in place of a processor.

Parameters:
DIV_4800, 16'd650, divisor value for br_cfg=00
DIV_9600, 16'd325, divisor value for br_cfg=01
DIV_19200, 16'd162, divisor value for br_cfg=10
DIV_38400, 16'd80, divisor value for br_cfg=11

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  synchronous, active-high reset
br_cfg  input  2  baud-rate select (switches); may change at any time
rda  input  1  receive data available, from SPART
tbr  input  1  transmit buffer ready, from SPART
databus_in  input  8  read data from SPART; valid combinationally during a read cycle
iocs  output  1  chip select, one-cycle pulse per access
iorw  output  1  1 = read, 0 = write
ioaddr  output  2  00 = tx/rx buffer, 01 = status, 10 = divisor low, 11 = divisor high
databus_out  output  8  write data; meaningful only when iocs=1 and iorw=0
echo_count  output  8  number of completed echo writes, wraps 255->0

Behaviour:
- Reset (rst=1 at a rising edge):
  - next state CFG_LO; iocs=0, iorw=1, ioaddr=00, databus_out=0, echo_count=0.
  - held-byte register cleared; cfg_shadow loaded with br_cfg.
  - Reset mid-operation abandons any access. No partial write is issued.
- All outputs are registered. An access is exactly one cycle with iocs=1. In every other cycle: iocs=0, iorw=1, ioaddr=00, databus_out=0.
- Divisor selection: div = DIV_x indexed by cfg_shadow.
- States:
  - CFG_LO: one write cycle, ioaddr=10, databus_out=div[7:0]. Then CFG_HI.
  - CFG_HI: one write cycle, ioaddr=11, databus_out=div[15:8]. Then IDLE.
    - Low byte is always written before high byte.
  - IDLE: iocs=0. Priority order:
    1. rda=1 -> READ_RX.
    2. Else br_cfg != cfg_shadow -> load cfg_shadow, go to CFG_LO.
    3. Else stay.
  - READ_RX: one read cycle, iorw=1, ioaddr=00. databus_in is captured into the held byte at the end of this cycle. Then WAIT_TBR.
  - WAIT_TBR: iocs=0. tbr=1 -> WRITE_TX, else stay (unbounded wait).
  - WRITE_TX: one write cycle, iorw=0, ioaddr=00, databus_out=held byte. echo_count increments at the end of the cycle. Then IDLE.
- Latency:
  - rda seen high in IDLE -> read strobe 1 cycle later.
  - tbr seen high in WAIT_TBR -> write strobe 1 cycle later.
  - Minimum IDLE-to-IDLE echo: 4 cycles.
- Boundary rules:
  - rda and a br_cfg change in the same IDLE cycle: the echo completes first. Reprogramming follows on return to IDLE.
  - br_cfg changes while not in IDLE: detected only in IDLE. Back-to-back changes before IDLE produce one reprogram with the latest value.
  - rda still high in the IDLE cycle after WRITE_TX: a new read starts (no suppression).
  - echo_count 255 + 1 -> 0.
  - Status register (ioaddr=01) is never accessed; rda/tbr are direct inputs.

Test Plan:
- Reset with br_cfg=01, rst deasserted at cycle 0 -> cycle 1: iocs=1, iorw=0, ioaddr=10, databus_out=8'h45; cycle 2: ioaddr=11, databus_out=8'h01; cycle 3: iocs=0.
- In IDLE, pulse rda with databus_in=8'hAA, tbr=1 -> read cycle (iorw=1, ioaddr=00), then write cycle with databus_out=8'hAA; echo_count 0->1.
- rda with databus_in=8'h39, tbr held 0 for 100 cycles -> iocs=0 throughout the wait; write of 8'h39 occurs exactly 1 cycle after tbr rises.
- In IDLE, change br_cfg 01->11 in the same cycle as rda=1 -> echo read/write first, then divisor writes 8'h50 then 8'h00.
- Assert rst during WAIT_TBR -> no tx write ever issued; next cycles show a CFG_LO/CFG_HI sequence; echo_count=0.
- 256 consecutive echoes -> echo_count returns to 8'h00; all written bytes equal the corresponding read bytes.
